// File: rtl/burst_memory.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : burst_memory
// Brief   : Single-port word memory accessed through burst commands. A write
//           burst stores byte-strobed beats at consecutive addresses; a read
//           burst streams words out under a valid/ready handshake. Addresses
//           wrap from DEPTH-1 to 0; a start address beyond DEPTH is rejected
//           with an error pulse.
// Revision: 1.0 - initial release
// ============================================================================
module burst_memory #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int MAX_LEN = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = $clog2(MAX_LEN),
  localparam int SB         = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [SB-1:0]         wstrb,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rlast,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  // DEPTH held one bit wider than the address so a power-of-two DEPTH is representable
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic                  done_q;
  logic                  err_q;

  logic                  cmd_acc;
  logic                  addr_ok;
  logic                  wr_beat;
  logic                  rd_beat;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  beat_inc;

  // Ready is combinational on reset so it is high in the very first cycle after release
  assign cmd_ready = (state_q == IDLE) && !res;
  assign wready    = (state_q == WR);
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign rlast     = rlast_q;
  assign done      = done_q;
  assign err       = err_q;

  assign cmd_acc   = cmd_valid && cmd_ready;
  assign addr_ok   = ({1'b0, addr} < DEPTH_EXT);
  assign wr_beat   = (state_q == WR) && wvalid;
  assign rd_beat   = (state_q == RD) && rvalid_q && rready;
  assign last_beat = (beat_q == len_q);
  assign beat_inc  = beat_q + LEN_WIDTH'(1);
  assign next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_WIDTH'(1);

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: leave IDLE on a legal command, return after the final beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_acc && addr_ok) begin
          state_d = wr_rd ? WR : RD;
        end
      end
      WR: begin
        if (wr_beat && last_beat) begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (rd_beat && rlast_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: command capture, strobed writes, read pipeline and completion pulses
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cur_addr_q <= '0;
      beat_q     <= '0;
      len_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_acc) begin
            if (!addr_ok) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              cur_addr_q <= addr;
              len_q      <= len;
              beat_q     <= '0;
              if (!wr_rd) begin
                // First read beat is fetched at acceptance so it is visible next cycle
                rdata_q  <= mem_q[addr];
                rvalid_q <= 1'b1;
                rlast_q  <= (len == '0);
              end
            end
          end
        end
        WR: begin
          if (wr_beat) begin
            for (int b = 0; b < SB; b++) begin
              if (wstrb[b]) begin
                mem_q[cur_addr_q][8*b +: 8] <= wdata[8*b +: 8];
              end
            end
            cur_addr_q <= next_addr;
            beat_q     <= beat_inc;
            if (last_beat) begin
              done_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (rd_beat) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              rdata_q    <= mem_q[next_addr];
              cur_addr_q <= next_addr;
              beat_q     <= beat_inc;
              rlast_q    <= (beat_inc == len_q);
            end
          end
        end
        default: begin
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_memory.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_burst_memory
// Brief   : Scoreboard bench for burst_memory. A bench-side memory model is
//           updated on every write beat; read commands push the expected
//           words into a queue that is popped as beats are handshaken.
//           A second instance with DEPTH=20 exercises out-of-range commands.
// Revision: 1.0 - initial release
// ============================================================================
module tb_burst_memory;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 32;
  localparam int MAX_LEN = 8;
  localparam int AW      = 5;
  localparam int LW      = 3;
  localparam int SB      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             res = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_valid_b = 1'b0;
  logic             wr_rd = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [LW-1:0]    len = '0;
  logic             wvalid = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [SB-1:0]    wstrb = '0;
  logic             rready = 1'b0;

  logic             cmd_ready, wready, rvalid, rlast, done, err;
  logic [WIDTH-1:0] rdata;
  logic             cmd_ready_b, wready_b, rvalid_b, rlast_b, done_b, err_b;
  logic [WIDTH-1:0] rdata_b;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] wbuf [8];

  burst_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .res(res), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wr_rd(wr_rd), .addr(addr), .len(len), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rlast(rlast), .done(done), .err(err)
  );

  burst_memory #(.WIDTH(WIDTH), .DEPTH(20), .MAX_LEN(MAX_LEN)) dut_b (
    .clk(clk), .res(res), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .wr_rd(wr_rd), .addr(addr), .len(len), .wvalid(wvalid), .wready(wready_b),
    .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid_b), .rready(rready),
    .rdata(rdata_b), .rlast(rlast_b), .done(done_b), .err(err_b)
  );

  // Issue a write burst at the current negedge; returns at the negedge of the done cycle
  task automatic do_write(input int a, input int l, input logic [SB-1:0] s);
    cmd_valid = 1'b1; wr_rd = 1'b1; addr = AW'(a); len = LW'(l);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i <= l; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = s;
      for (int b = 0; b < SB; b++) begin
        if (s[b]) model_mem[(a + i) % DEPTH][8*b +: 8] = wbuf[i][8*b +: 8];
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wstrb = '0;
  endtask

  // Issue a read burst, push expectations, then pop/compare each handshaken beat
  task automatic run_read(input string name, input int a, input int l, input logic [31:0] pat);
    int               got;
    logic             stalled;
    logic             fin;
    logic [WIDTH-1:0] hd;
    logic             hl;
    logic [WIDTH-1:0] e;
    logic             el;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_issue: cmd_ready=%b expected 1", name, cmd_ready);
    end
    for (int i = 0; i <= l; i++) exp_q.push_back(model_mem[(a + i) % DEPTH]);
    cmd_valid = 1'b1; wr_rd = 1'b0; addr = AW'(a); len = LW'(l); rready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++;
    if (rvalid !== 1'b1) begin
      n_err++; $display("FAIL %s_latency: rvalid=%b expected 1 one cycle after accept", name, rvalid);
    end
    got = 0; stalled = 1'b0; fin = 1'b0; hd = '0; hl = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (stalled) begin
        n_vec++;
        if (rvalid !== 1'b1 || rdata !== hd || rlast !== hl) begin
          n_err++;
          $display("FAIL %s_hold: rvalid=%b rdata=%h rlast=%b expected 1 %h %b",
                   name, rvalid, rdata, rlast, hd, hl);
        end
      end
      rready = pat[k % 32];
      if (rvalid === 1'b1 && rready) begin
        e  = exp_q.pop_front();
        el = (got == l);
        n_vec++;
        if (rdata !== e || rlast !== el) begin
          n_err++;
          $display("FAIL %s_beat%0d: rdata=%h rlast=%b expected %h %b", name, got, rdata, rlast, e, el);
        end
        got++;
        if (got == l + 1) fin = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = (rvalid === 1'b1);
        hd = rdata; hl = rlast;
      end
      @(negedge clk);
    end
    rready = 1'b0;
    n_vec++;
    if (!fin) begin
      n_err++; $display("FAIL %s_timeout: got %0d beats expected %0d", name, got, l + 1);
      exp_q.delete();
    end else if (done !== 1'b1 || err !== 1'b0 || rvalid !== 1'b0) begin
      n_err++; $display("FAIL %s_done: done=%b err=%b rvalid=%b expected 1 0 0", name, done, err, rvalid);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
    n_vec++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || wready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rvalid=%b rlast=%b wready=%b done=%b err=%b rdata=%h expected all 0",
               rvalid, rlast, wready, done, err, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    run_read("rd_len0", 5, 0, '1);
  endtask

  task automatic test_burst_write_read();
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
    do_write(3, 3, 2'b11);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL wr_burst_done: done=%b err=%b expected 1 0", done, err);
    end
    run_read("rd_burst", 3, 3, '1);
  endtask

  task automatic test_wrap();
    wbuf[0] = 16'hA0A1; wbuf[1] = 16'hB0B1; wbuf[2] = 16'hC0C1; wbuf[3] = 16'hD0D1;
    do_write(30, 3, 2'b11);
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_err++; $display("FAIL wrap_wr_done: done=%b err=%b expected 1 0", done, err);
    end
    run_read("rd_wrap", 30, 3, '1);
    run_read("rd_wrap_low", 0, 1, '1);
  endtask

  task automatic test_strobe();
    wbuf[0] = 16'hABCD;
    do_write(7, 0, 2'b11);
    wbuf[0] = 16'h1234;
    do_write(7, 0, 2'b01);
    run_read("rd_strb_lo", 7, 0, '1);
    wbuf[0] = 16'h5678;
    do_write(7, 0, 2'b10);
    run_read("rd_strb_hi", 7, 0, '1);
  endtask

  task automatic test_stall();
    run_read("rd_stall", 3, 3, 32'hFFFF_FFF9);
    run_read("rd_stall_alt", 29, 5, 32'hAAAA_AAAA);
  endtask

  task automatic test_error();
    @(negedge clk);
    n_vec++;
    if (cmd_ready_b !== 1'b1) begin
      n_err++; $display("FAIL err_issue: cmd_ready=%b expected 1", cmd_ready_b);
    end
    cmd_valid_b = 1'b1; wr_rd = 1'b1; addr = AW'(25); len = '0;
    @(negedge clk);
    cmd_valid_b = 1'b0;
    wvalid = 1'b1; wdata = 16'hFFFF; wstrb = 2'b11;
    n_vec++;
    if (done_b !== 1'b1 || err_b !== 1'b1 || wready_b !== 1'b0 || cmd_ready_b !== 1'b1) begin
      n_err++;
      $display("FAIL err_pulse: done=%b err=%b wready=%b cmd_ready=%b expected 1 1 0 1",
               done_b, err_b, wready_b, cmd_ready_b);
    end
    @(negedge clk);
    wvalid = 1'b0; wstrb = '0;
    n_vec++;
    if (done_b !== 1'b0 || err_b !== 1'b0 || rvalid_b !== 1'b0 || rlast_b !== 1'b0 || rdata_b !== '0) begin
      n_err++;
      $display("FAIL err_after: done=%b err=%b rvalid=%b rlast=%b rdata=%h expected 0 0 0 0 0000",
               done_b, err_b, rvalid_b, rlast_b, rdata_b);
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h9000 + 16'(i);
    cmd_valid = 1'b1; wr_rd = 1'b1; addr = '0; len = 3'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = 2'b11;
      @(negedge clk);
    end
    wvalid = 1'b1; wdata = wbuf[2]; res = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; wstrb = '0;
    n_vec++;
    if (done !== 1'b0 || cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_held: done=%b cmd_ready=%b expected 0 0", done, cmd_ready);
    end
    res = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || wready !== 1'b0) begin
      n_err++; $display("FAIL midrst_release: cmd_ready=%b done=%b wready=%b expected 1 0 0", cmd_ready, done, wready);
    end
    @(negedge clk);
    for (int a = 0; a < DEPTH; a += 8) run_read("rd_cleared", a, 7, '1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_wrap();
    test_strobe();
    test_stall();
    test_error();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
